// File: rtl/sim_uart_console_bridge.sv
// sim_uart_console_bridge
// Glue between SimTop's UART pins and the simulation host.
// RX: host-injected characters are queued in a small FIFO and returned to
// SimTop polls with zero latency; EMPTY_CH is returned when nothing is queued.
// TX: SimTop's output characters are gathered into a line buffer that is
// handed to the host in one piece on newline, when the buffer is full, or on
// an explicit flush request.
module sim_uart_console_bridge #(
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_LINE  = 64,
    parameter logic [7:0]  EMPTY_CH = 8'hff
) (
    input  logic                         clock,
    input  logic                         reset,
    // SimTop side
    input  logic                         uart_out_valid,
    input  logic [7:0]                   uart_out_ch,
    input  logic                         uart_in_valid,
    output logic [7:0]                   uart_in_ch,
    // host RX injection
    input  logic                         host_rx_valid,
    output logic                         host_rx_ready,
    input  logic [7:0]                   host_rx_ch,
    // host TX line hand-off
    output logic                         host_tx_valid,
    input  logic                         host_tx_ready,
    output logic [8*TX_LINE-1:0]         host_tx_data,
    output logic [$clog2(TX_LINE+1)-1:0] host_tx_len,
    input  logic                         tx_flush,
    output logic [31:0]                  tx_drop_cnt
);

    // Pointer width carries one extra wrap bit so full and empty differ.
    localparam int unsigned PW = $clog2(RX_DEPTH);
    localparam int unsigned LW = $clog2(TX_LINE + 1);
    localparam int unsigned IW = $clog2(TX_LINE);
    localparam logic [LW-1:0] LINE_FULL = LW'(TX_LINE);
    localparam logic [7:0]    NEWLINE   = 8'h0A;

    typedef enum logic {
        TX_FILL  = 1'b0,
        TX_FLUSH = 1'b1
    } tx_state_e;

    // ------------------------------------------------------------------
    // RX FIFO state
    // ------------------------------------------------------------------
    logic [7:0]  rx_mem_q [RX_DEPTH];
    logic [7:0]  rx_mem_d [RX_DEPTH];
    logic [PW:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PW:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic        rx_empty;
    logic        rx_full;
    logic        rx_push;
    logic        rx_pop;

    // ------------------------------------------------------------------
    // TX line buffer state
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [7:0]  tx_line_q [TX_LINE];
    logic [7:0]  tx_line_d [TX_LINE];
    logic [LW-1:0] tx_count_q, tx_count_d;
    logic [31:0] tx_drop_q, tx_drop_d;

    // Occupancy flags from the wrap-bit pointer pair, plus handshake decode.
    always_comb begin
        rx_empty      = (rx_wr_ptr_q == rx_rd_ptr_q);
        rx_full       = (rx_wr_ptr_q[PW] != rx_rd_ptr_q[PW]) &&
                        (rx_wr_ptr_q[PW-1:0] == rx_rd_ptr_q[PW-1:0]);
        host_rx_ready = !rx_full;
        rx_push       = host_rx_valid && !rx_full;
        rx_pop        = uart_in_valid && !rx_empty;
        uart_in_ch    = rx_empty ? EMPTY_CH : rx_mem_q[rx_rd_ptr_q[PW-1:0]];
    end

    // Next FIFO contents and pointers; push and pop are independent, so a
    // push blocked by full stays blocked even if a pop happens this cycle.
    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_ptr_q[PW-1:0]] = host_rx_ch;
            rx_wr_ptr_d = rx_wr_ptr_q + (PW+1)'(1);
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + (PW+1)'(1);
        end
    end

    // RX FIFO registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            for (int i = 0; i < int'(RX_DEPTH); i++) begin
                rx_mem_q[i] <= '0;
            end
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_mem_q    <= rx_mem_d;
        end
    end

    // TX line FSM: append in FILL, hold the line for the host in FLUSH and
    // count any characters that arrive while the line is being handed off.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_line_d  = tx_line_q;
        tx_count_d = tx_count_q;
        tx_drop_d  = tx_drop_q;
        unique case (tx_state_q)
            TX_FILL: begin
                if (uart_out_valid) begin
                    tx_line_d[tx_count_q[IW-1:0]] = uart_out_ch;
                    tx_count_d = tx_count_q + LW'(1);
                    if ((uart_out_ch == NEWLINE) || (tx_count_d == LINE_FULL)) begin
                        tx_state_d = TX_FLUSH;
                    end
                end
                if (tx_flush && (tx_count_d != '0)) begin
                    tx_state_d = TX_FLUSH;
                end
            end
            TX_FLUSH: begin
                if (uart_out_valid && (tx_drop_q != 32'hffff_ffff)) begin
                    tx_drop_d = tx_drop_q + 32'd1;
                end
                if (host_tx_ready) begin
                    for (int i = 0; i < int'(TX_LINE); i++) begin
                        tx_line_d[i] = '0;
                    end
                    tx_count_d = '0;
                    tx_state_d = TX_FILL;
                end
            end
            default: begin
                tx_state_d = TX_FILL;
            end
        endcase
    end

    // TX registers; reset drops any partial or pending line at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_FILL;
            tx_count_q <= '0;
            tx_drop_q  <= '0;
            for (int i = 0; i < int'(TX_LINE); i++) begin
                tx_line_q[i] <= '0;
            end
        end else begin
            tx_state_q <= tx_state_d;
            tx_count_q <= tx_count_d;
            tx_drop_q  <= tx_drop_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // Host-facing view of the line; unused bytes are already zero.
    always_comb begin
        host_tx_valid = (tx_state_q == TX_FLUSH);
        host_tx_len   = (tx_state_q == TX_FLUSH) ? tx_count_q : '0;
        tx_drop_cnt   = tx_drop_q;
        host_tx_data  = '0;
        for (int i = 0; i < int'(TX_LINE); i++) begin
            host_tx_data[8*i +: 8] = tx_line_q[i];
        end
    end

endmodule

// File: tb/tb_sim_uart_console_bridge.sv
// Directed testbench for sim_uart_console_bridge: a linear sequence of
// steps with hand-computed expectations checked by immediate assertions.
module tb_sim_uart_console_bridge;

    localparam int TX_LINE = 64;

    logic                 clock;
    logic                 reset;
    logic                 uart_out_valid;
    logic [7:0]           uart_out_ch;
    logic                 uart_in_valid;
    logic [7:0]           uart_in_ch;
    logic                 host_rx_valid;
    logic                 host_rx_ready;
    logic [7:0]           host_rx_ch;
    logic                 host_tx_valid;
    logic                 host_tx_ready;
    logic [8*TX_LINE-1:0] host_tx_data;
    logic [6:0]           host_tx_len;
    logic                 tx_flush;
    logic [31:0]          tx_drop_cnt;

    int checks = 0;
    int errors = 0;

    sim_uart_console_bridge #(
        .RX_DEPTH (16),
        .TX_LINE  (TX_LINE),
        .EMPTY_CH (8'hff)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .uart_out_valid (uart_out_valid),
        .uart_out_ch    (uart_out_ch),
        .uart_in_valid  (uart_in_valid),
        .uart_in_ch     (uart_in_ch),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .host_rx_ch     (host_rx_ch),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_tx_data   (host_tx_data),
        .host_tx_len    (host_tx_len),
        .tx_flush       (tx_flush),
        .tx_drop_cnt    (tx_drop_cnt)
    );

    // 10 time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One host injection cycle.
    task automatic push(input logic [7:0] ch);
        host_rx_valid = 1'b1;
        host_rx_ch    = ch;
        tick();
        host_rx_valid = 1'b0;
    endtask

    // One SimTop emit cycle.
    task automatic emit(input logic [7:0] ch);
        uart_out_valid = 1'b1;
        uart_out_ch    = ch;
        tick();
        uart_out_valid = 1'b0;
    endtask

    // One poll cycle, checking the char returned in that same cycle.
    task automatic poll(input string tag, input logic [7:0] expected);
        uart_in_valid = 1'b1;
        #1;
        check(tag, 64'(uart_in_ch), 64'(expected));
        tick();
        uart_in_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        uart_out_valid = 1'b0;
        uart_out_ch    = '0;
        uart_in_valid  = 1'b0;
        host_rx_valid  = 1'b0;
        host_rx_ch     = '0;
        host_tx_ready  = 1'b0;
        tx_flush       = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_rx_ready", 64'(host_rx_ready), 64'd1);
        check("rst_tx_valid", 64'(host_tx_valid), 64'd0);
        check("rst_tx_len",   64'(host_tx_len),   64'd0);
        check("rst_drop",     64'(tx_drop_cnt),   64'd0);
        check("rst_in_ch",    64'(uart_in_ch),    64'hff);
        reset = 1'b0;
        tick();

        // 1: three pushes, four polls
        push(8'h61);
        push(8'h62);
        push(8'h63);
        poll("t1_poll0", 8'h61);
        poll("t1_poll1", 8'h62);
        poll("t1_poll2", 8'h63);
        poll("t1_poll3", 8'hff);
        check("t1_empty_after", 64'(uart_in_ch), 64'hff);

        // 2: fill the FIFO (pointers wrap), then push+poll while full
        for (int i = 0; i < 16; i++) begin
            check("t2_ready_before", 64'(host_rx_ready), 64'd1);
            push(8'(8'h10 + i));
        end
        check("t2_ready_full", 64'(host_rx_ready), 64'd0);
        host_rx_valid = 1'b1;
        host_rx_ch    = 8'hEE;
        uart_in_valid = 1'b1;
        #1;
        check("t2_head_full", 64'(uart_in_ch), 64'h10);
        tick();
        host_rx_valid = 1'b0;
        uart_in_valid = 1'b0;
        check("t2_ready_15", 64'(host_rx_ready), 64'd1);
        for (int i = 1; i < 16; i++) begin
            poll("t2_drain", 8'(8'h10 + i));
        end
        poll("t2_drained_empty", 8'hff);

        // 3: "hi\n" with host not ready
        emit(8'h68);
        emit(8'h69);
        check("t3_valid_mid", 64'(host_tx_valid), 64'd0);
        emit(8'h0A);
        check("t3_valid", 64'(host_tx_valid), 64'd1);
        check("t3_len",   64'(host_tx_len),   64'd3);
        check("t3_data",  64'(host_tx_data[31:0]), 64'h000A6968);
        tick();
        check("t3_hold",  64'(host_tx_data[23:0]), 64'h0A6968);
        host_tx_ready = 1'b1;
        tick();
        host_tx_ready = 1'b0;
        check("t3_valid_after", 64'(host_tx_valid), 64'd0);
        check("t3_len_after",   64'(host_tx_len),   64'd0);
        check("t3_data_after",  64'(host_tx_data[23:0]), 64'h0);

        // 4: full line of 64 chars, then drops while pending
        for (int i = 0; i < 64; i++) begin
            emit(8'(8'h20 + i));
        end
        check("t4_valid", 64'(host_tx_valid), 64'd1);
        check("t4_len",   64'(host_tx_len),   64'd64);
        check("t4_first", 64'(host_tx_data[7:0]),     64'h20);
        check("t4_last",  64'(host_tx_data[511:504]), 64'h5F);
        emit(8'h41);
        emit(8'h42);
        check("t4_drop2", 64'(tx_drop_cnt), 64'd2);
        check("t4_first_kept", 64'(host_tx_data[7:0]), 64'h20);
        host_tx_ready  = 1'b1;
        uart_out_valid = 1'b1;
        uart_out_ch    = 8'h5A;
        tick();
        host_tx_ready  = 1'b0;
        uart_out_valid = 1'b0;
        check("t4_drop_accept", 64'(tx_drop_cnt), 64'd3);
        check("t4_valid_after", 64'(host_tx_valid), 64'd0);
        check("t4_data_clear",  64'(host_tx_data[7:0]), 64'h0);

        // 5: explicit flush of a partial line, then flush with empty buffer
        emit(8'h6F);
        emit(8'h6B);
        check("t5_no_valid", 64'(host_tx_valid), 64'd0);
        tx_flush = 1'b1;
        tick();
        tx_flush = 1'b0;
        check("t5_valid", 64'(host_tx_valid), 64'd1);
        check("t5_len",   64'(host_tx_len),   64'd2);
        check("t5_data",  64'(host_tx_data[23:0]), 64'h006B6F);
        host_tx_ready = 1'b1;
        tick();
        host_tx_ready = 1'b0;
        tx_flush = 1'b1;
        tick();
        tx_flush = 1'b0;
        check("t5_empty_flush", 64'(host_tx_valid), 64'd0);
        tick();
        check("t5_empty_flush2", 64'(host_tx_valid), 64'd0);

        // 6: reset while a line is pending and 5 chars are queued
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h30 + i));
        end
        emit(8'h78);
        emit(8'h0A);
        check("t6_valid_pre", 64'(host_tx_valid), 64'd1);
        check("t6_head_pre",  64'(uart_in_ch),    64'h30);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid_rst", 64'(host_tx_valid), 64'd0);
        check("t6_in_ch_rst", 64'(uart_in_ch),    64'hff);
        check("t6_drop_rst",  64'(tx_drop_cnt),   64'd0);
        tick();
        reset = 1'b0;
        tick();
        poll("t6_poll_after", 8'hff);
        check("t6_len_after", 64'(host_tx_len), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
